// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI byte stream to register-file bridge with command decode,
// address auto-increment, read staging and chip-select abort.
module spi_reg_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              err_clr,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, WR_DATA, RD_ISSUE, RD_CAP, RD_DATA} state_t;

    state_t            state_q, state_d;
    logic              cs_meta_q, cs_sync_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d, wdata_q, wdata_d;
    logic              we_q, we_d, inc_q, inc_d, err_q, err_d, err_set;
    logic              cs_act, addr_ok;

    assign cs_act  = ~cs_sync_q;
    assign addr_ok = int'(addr_q) < NUM_REGS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            addr_q    <= '0;
            dout_q    <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            inc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            inc_q     <= inc_d;
            err_q     <= err_d;
        end
    end

    // A write increments the address one cycle after the strobe, so the
    // strobe cycle still presents the address that was written.
    always_comb begin
        state_d = state_q;
        addr_d  = inc_q ? addr_q + 1'b1 : addr_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        inc_d   = 1'b0;
        err_set = 1'b0;
        if (!cs_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (byte_sync) begin
                    addr_d  = data_in[ADDR_W-1:0];
                    state_d = data_in[7] ? WR_DATA : RD_ISSUE;
                end
                WR_DATA: if (byte_sync) begin
                    inc_d   = 1'b1;
                    we_d    = addr_ok;
                    wdata_d = data_in;
                    err_set = ~addr_ok;
                end
                RD_ISSUE: begin
                    err_set = byte_sync;
                    state_d = RD_CAP;
                end
                RD_CAP: begin
                    dout_d  = addr_ok ? reg_rdata : 8'h00;
                    err_set = ~addr_ok | byte_sync;
                    state_d = RD_DATA;
                end
                RD_DATA: if (byte_sync) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end
        err_d = err_set | (err_q & ~err_clr);
    end

    assign data_out  = dout_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = cs_act && state_q == RD_ISSUE && addr_ok;
    assign err       = err_q;
endmodule
